fetch_unit: RTL and testbench

Instruction fetch stage for the single-cycle RV32I core, sitting between the program counter/instruction memory and the control unit. Owns the fetch PC and issues one-word reads to a synchronous instruction memory with one-cycle read latency. Buffers returned words with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. Branch redirects (PCsrc plus target) flush everything younger than the redirect.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited reads to a 1-cycle imem,
// buffers {instr, pc} in a small FIFO for decode. Optional counters under FETCH_STATS_EN.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  instr_valid,
  input  logic                  instr_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] addr;
  } entry_t;

  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic                  pop, push;
  logic [OCC_W-1:0]      occ;
  logic                  unused_tgt_lsb;

  assign unused_tgt_lsb = ^redirect_target[1:0];
  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid & instr_ready;
  assign imem_addr      = fpc_q;
  assign instr          = instr_valid ? mem_q[rd_ptr_q].word : DATA_WIDTH'(32'h13);
  assign pc             = instr_valid ? mem_q[rd_ptr_q].addr : '0;

  // Credit: buffered + in flight, net of this cycle's pop, must leave room for one more.
  assign occ      = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign imem_req = !rst && !redirect && (occ < OCC_W'(FIFO_DEPTH) + OCC_W'(pop));

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mem_d         = mem_q;
    push          = inflight_q & !redirect;
    if (redirect) begin
      // Flush wins over the pop and any response landing this cycle.
      fpc_d    = {redirect_target[DATA_WIDTH-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (imem_req) begin
        fpc_d         = fpc_q + DATA_WIDTH'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = fpc_q;
      end
      if (push) begin
        mem_d[wr_ptr_q] = '{word: imem_rdata, addr: inflight_pc_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mem_q         <= mem_d;
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q + 32'(pop);
    stall_count_d = stall_count_q + 32'(instr_valid & !instr_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, async reset, stats.
module tb_fetch_unit;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = 32'hDEADBEEF;
  logic          redirect;
  logic [DW-1:0] redirect_target;
  logic [DW-1:0] instr, pc;
  logic          instr_valid;
  logic          instr_ready;
`ifdef FETCH_STATS_EN
  logic [31:0]   fetch_count, stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target),
    .instr(instr), .pc(pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Word at address a is 0x1000 + a; garbage when no read was issued.
  always @(posedge clk) imem_rdata <= imem_req ? 32'h1000 + imem_addr : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Structural invariants: bounded occupancy, never push into a full FIFO without a pop.
  always @(negedge clk) begin
    if (!rst) begin
      chk("occ_bound", 32'(dut.count_q <= DEPTH), 1);
      chk("no_overflow", 32'(dut.inflight_q && !redirect && (dut.count_q == DEPTH)
                             && !(instr_valid && instr_ready)), 0);
    end
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_pc", pc, 32'h0);

    // Streaming from reset
    @(posedge clk); #2; rst = 1'b0; #1;
    chk("c0_req", 32'(imem_req), 1);
    chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(instr_valid), 0);
    cyc; #1;
    chk("c1_valid", 32'(instr_valid), 0);
    chk("c1_addr", imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      cyc; #1;
      chk("str_valid", 32'(instr_valid), 1);
      chk("str_pc", pc, 32'(4 * k));
      chk("str_instr", instr, 32'(32'h1000 + 4 * k));
    end

    // Backpressure: ready low cycles 2..7
    do_reset; instr_ready = 1'b0;
    cyc; cyc;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("bp_req", 32'(imem_req), 0);
      chk("bp_head_pc", pc, 32'h0);
      chk("bp_valid", 32'(instr_valid), 1);
      cyc;
    end
    instr_ready = 1'b1; #1;
    chk("bp_resume_req", 32'(imem_req), 1);
    chk("bp_resume_addr", imem_addr, 32'h8);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin cyc; #1; end
      chk("bp_drain_valid", 32'(instr_valid), 1);
      chk("bp_drain_pc", pc, 32'(4 * k));
      chk("bp_drain_instr", instr, 32'(32'h1000 + 4 * k));
    end

    // Redirect to 0x40 with one entry buffered and one read in flight
    do_reset; instr_ready = 1'b0;
    cyc; cyc;
    redirect = 1'b1; redirect_target = 32'h40; #1;
    chk("rd_n_req", 32'(imem_req), 0);
    cyc; redirect = 1'b0; instr_ready = 1'b1; #1;
    chk("rd_n1_valid", 32'(instr_valid), 0);
    chk("rd_n1_req", 32'(imem_req), 1);
    chk("rd_n1_addr", imem_addr, 32'h40);
    cyc; #1;
    chk("rd_n2_valid", 32'(instr_valid), 0);
    chk("rd_n2_addr", imem_addr, 32'h44);
    cyc; #1;
    chk("rd_n3_valid", 32'(instr_valid), 1);
    chk("rd_n3_pc", pc, 32'h40);
    chk("rd_n3_instr", instr, 32'h1040);
    cyc; #1;
    chk("rd_n4_pc", pc, 32'h44);

    // Misaligned target is aligned down
    redirect = 1'b1; redirect_target = 32'h43; #1;
    chk("ra_n_req", 32'(imem_req), 0);
    cyc; redirect = 1'b0; #1;
    chk("ra_n1_valid", 32'(instr_valid), 0);
    chk("ra_n1_addr", imem_addr, 32'h40);
    cyc; cyc; #1;
    chk("ra_n3_pc", pc, 32'h40);

    // Wrap at the top of the address space
    redirect = 1'b1; redirect_target = 32'hFFFFFFF8; #1;
    chk("rw_n_req", 32'(imem_req), 0);
    cyc; redirect = 1'b0; #1;
    chk("rw_n1_addr", imem_addr, 32'hFFFFFFF8);
    cyc; #1;
    chk("rw_n2_addr", imem_addr, 32'hFFFFFFFC);
    cyc; #1;
    chk("rw_n3_addr", imem_addr, 32'h0);
    chk("rw_n3_pc", pc, 32'hFFFFFFF8);
    chk("rw_n3_instr", instr, 32'h00000FF8);
    cyc; #1;
    chk("rw_n4_pc", pc, 32'hFFFFFFFC);
    cyc; #1;
    chk("rw_n5_pc", pc, 32'h0);
    chk("rw_n5_instr", instr, 32'h1000);

    // Asynchronous reset with two entries buffered
    do_reset; instr_ready = 1'b0;
    cyc; cyc; cyc; #1;
    chk("ar_pre_count", 32'(dut.count_q), 2);
    rst = 1'b1; #1;
    chk("ar_valid", 32'(instr_valid), 0);
    chk("ar_req", 32'(imem_req), 0);
    chk("ar_count", 32'(dut.count_q), 0);
    chk("ar_instr", instr, 32'h13);
    @(posedge clk); #2; rst = 1'b0; instr_ready = 1'b1; #1;
    chk("ar_restart_addr", imem_addr, 32'h0);
    chk("ar_restart_req", 32'(imem_req), 1);
    cyc; cyc; #1;
    chk("ar_first_pc", pc, 32'h0);
    chk("ar_first_instr", instr, 32'h1000);

`ifdef FETCH_STATS_EN
    do_reset; instr_ready = 1'b1; #1;
    chk("st_rst_fetch", fetch_count, 0);
    chk("st_rst_stall", stall_count, 0);
    cyc; cyc;
    repeat (10) cyc;
    instr_ready = 1'b0;
    repeat (3) cyc;
    #1;
    chk("st_fetch", fetch_count, 10);
    chk("st_stall", stall_count, 3);
    rst = 1'b1; #1;
    chk("st_clr_fetch", fetch_count, 0);
    chk("st_clr_stall", stall_count, 0);
    @(posedge clk); #2; rst = 1'b0;
`endif

    cyc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
